timer_csr: RTL and testbench
============================

// Module: timer_csr
// PURPOSE
//  Memory-mapped control/status front-end for the timer core. Decodes bus accesses into
//  trigger/halt pulses, single_shot and compare_value; consumes active/match_occurred/counter.
//  Keeps sticky match/overrun flags and a match counter, and drives a level interrupt.
//  Sits between the SoC data bus and the timer core; both are instantiated side by side in the timer wrapper.
// PARAMETERS
//  ADDR_WIDTH       5   byte-address width; register index = addr[4:2]
//  MATCH_CNT_WIDTH  16  width of the saturating match counter (1..32)
// PORTS
//  clk             in   1               system clock
//  rst_n           in   1               asynchronous active-low reset
//  req             in   1               bus request
//  we              in   1               1 = write, 0 = read
//  addr            in   ADDR_WIDTH      byte address (word aligned; addr[1:0] ignored)
//  wdata           in   32              write data
//  gnt             out  1               request accepted (combinational = req)
//  rvalid          out  1               response valid, 1 cycle after each accepted req (reads and writes)
//  rdata           out  32              read data, valid with rvalid, 0 otherwise
//  irq             out  1               level interrupt = CR.IRQ_EN & SR.MATCH
//  tmr_trigger     out  1               1-cycle pulse to timer core trigger
//  tmr_halt        out  1               1-cycle pulse to timer core halt
//  tmr_single_shot out  1               CR.SINGLE_SHOT
//  tmr_compare     out  32              CMPR contents
//  tmr_active      in   1               timer core active
//  tmr_match       in   1               timer core match_occurred (1-cycle per match)
//  tmr_counter     in   32              timer core counter
// BEHAVIOUR
//  Reset: all registers 0; gnt=req, rvalid=0, rdata=0, irq=0, tmr_* outputs 0.
//  Bus: always ready; access accepted in cycle with req=1; write state updates at that clock edge;
//   rvalid=1 and rdata registered on the following cycle. Back-to-back requests every cycle supported.
//  Map (index = addr[4:2]):
//   0 CR  [0] TRIGGER W1 pulse, reads 0; [1] HALT W1 pulse, reads 0; [2] SINGLE_SHOT RW; [3] IRQ_EN RW
//   1 SR  [0] ACTIVE RO (tmr_active); [1] MATCH sticky W1C; [2] OVERRUN sticky W1C
//   2 CMPR RW 32 bits -> tmr_compare, takes effect cycle after write, also while counting
//   3 CNTR RO tmr_counter sampled in the accept cycle
//   4 MCNT RO match counter zero-extended; any write clears it
//   5..7 unmapped: read 0, write ignored, still respond with rvalid
//  Pulses: write to CR registers tmr_trigger/tmr_halt high exactly the next cycle for one cycle;
//   HALT and TRIGGER both 1 in one write -> only tmr_halt pulses. SINGLE_SHOT updates in same edge,
//   so a write of SINGLE_SHOT+TRIGGER presents the new mode together with the trigger pulse.
//  MATCH: set on tmr_match=1. OVERRUN: set on tmr_match=1 while MATCH already 1.
//   Same-cycle W1C and tmr_match: set wins for MATCH; OVERRUN set only if MATCH was 1 before the edge.
//  MCNT: +1 per tmr_match, saturates at 2^MATCH_CNT_WIDTH-1; write-clear and match same cycle -> value 1.
//  irq: registered flags, combinational AND; drops cycle after MATCH cleared or IRQ_EN cleared.
//  Reset mid-access: outstanding rvalid dropped, no response issued.
// STRUCTURE
//  timer_pkg: register index constants (CR/SR/CMPR/CNTR/MCNT), bit-position localparams,
//   packed struct typedefs cr_t and sr_t. No sub-module; single always_ff + always_comb decode.
// TESTING
//  Reset -> read all 5 regs: all 0, irq=0; read index 6 -> rdata=0, rvalid=1.
//  Write CMPR=3, CR=0x5 (SS+TRIG) -> one tmr_trigger pulse; with core: SR.MATCH=1, MCNT=1, SR.ACTIVE=0 after.
//  CR=0x8, continuous run CMPR=1, no clear -> irq=1, OVERRUN=1 after 2nd match; write SR=0x6 -> irq=0.
//  Write CR=0x3 -> only tmr_halt pulses; tmr_trigger stays 0.
//  Force tmr_match on same cycle as SR W1C of MATCH -> MATCH stays 1; MCNT clear + match -> MCNT=1.
//  MATCH_CNT_WIDTH=2, 5 matches -> MCNT=3; assert rst_n during read -> no rvalid, all outputs 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Register map, bit positions and flag structs shared by the timer CSR block.
// Holds no logic; only types and constants.
package timer_pkg;

    localparam logic [2:0] IDX_CR   = 3'd0;
    localparam logic [2:0] IDX_SR   = 3'd1;
    localparam logic [2:0] IDX_CMPR = 3'd2;
    localparam logic [2:0] IDX_CNTR = 3'd3;
    localparam logic [2:0] IDX_MCNT = 3'd4;

    localparam int CR_TRIGGER     = 0;
    localparam int CR_HALT        = 1;
    localparam int CR_SINGLE_SHOT = 2;
    localparam int CR_IRQ_EN      = 3;

    localparam int SR_ACTIVE  = 0;
    localparam int SR_MATCH   = 1;
    localparam int SR_OVERRUN = 2;

    typedef struct packed {
        logic irq_en;
        logic single_shot;
    } cr_t;

    typedef struct packed {
        logic overrun;
        logic match;
    } sr_t;

endpackage

// File: rtl/timer_csr_if.sv
// Simple always-ready data bus: req/we/addr/wdata in, gnt/rvalid/rdata out.
// master = bus initiator, slave = register block.
interface timer_csr_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/timer_csr.sv
// Control/status front-end for the timer core: decodes bus accesses into
// trigger/halt pulses, mode and compare value; keeps sticky match/overrun flags,
// a saturating match counter and a level interrupt.
// Ports: clk, rst_n (async low), bus (slave modport), irq,
//   tmr_trigger/tmr_halt/tmr_single_shot/tmr_compare to the core,
//   tmr_active/tmr_match/tmr_counter from the core.
module timer_csr
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH      = 5,
    parameter int MATCH_CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    timer_csr_if.slave  bus,
    output logic        irq,
    output logic        tmr_trigger,
    output logic        tmr_halt,
    output logic        tmr_single_shot,
    output logic [31:0] tmr_compare,
    input  logic        tmr_active,
    input  logic        tmr_match,
    input  logic [31:0] tmr_counter
);

    localparam int MW = MATCH_CNT_WIDTH;

    logic [2:0]    idx;
    logic          wr;
    logic          rd;
    logic          sel_cr;
    logic          sel_sr;
    logic          sel_cmpr;
    logic          sel_cntr;
    logic          sel_mcnt;

    cr_t           cr_q, cr_d;
    sr_t           sr_q, sr_d;
    logic [31:0]   cmpr_q, cmpr_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          trig_q, trig_d;
    logic          halt_q, halt_d;
    logic          rvalid_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          w1c_match;
    logic          w1c_ovr;
    logic          unused_addr;

    assign idx = bus.addr[4:2];
    assign wr  = bus.req & bus.we;
    assign rd  = bus.req & ~bus.we;

    // Byte-offset bits and any address bits above the map are don't-care.
    assign unused_addr = ^bus.addr;

    assign sel_cr   = (idx == IDX_CR);
    assign sel_sr   = (idx == IDX_SR);
    assign sel_cmpr = (idx == IDX_CMPR);
    assign sel_cntr = (idx == IDX_CNTR);
    assign sel_mcnt = (idx == IDX_MCNT);

    assign w1c_match = wr & sel_sr & bus.wdata[SR_MATCH];
    assign w1c_ovr   = wr & sel_sr & bus.wdata[SR_OVERRUN];

    always_comb begin
        cr_d    = cr_q;
        cmpr_d  = cmpr_q;
        mcnt_d  = mcnt_q;
        trig_d  = 1'b0;
        halt_d  = 1'b0;
        rdata_d = '0;

        if (wr && sel_cr) begin
            cr_d.single_shot = bus.wdata[CR_SINGLE_SHOT];
            cr_d.irq_en      = bus.wdata[CR_IRQ_EN];
            // Halt dominates a simultaneous trigger request.
            halt_d = bus.wdata[CR_HALT];
            trig_d = bus.wdata[CR_TRIGGER] & ~bus.wdata[CR_HALT];
        end

        if (wr && sel_cmpr) begin
            cmpr_d = bus.wdata;
        end

        // Set beats clear; overrun looks at MATCH as it was before this edge.
        sr_d.match   = (sr_q.match & ~w1c_match) | tmr_match;
        sr_d.overrun = (sr_q.overrun & ~w1c_ovr)
                     | (tmr_match & sr_q.match);

        if (wr && sel_mcnt) begin
            mcnt_d = tmr_match ? MW'(1) : '0;
        end else if (tmr_match && (mcnt_q != '1)) begin
            mcnt_d = mcnt_q + MW'(1);
        end

        unique case (1'b1)
            sel_cr: begin
                rdata_d[CR_SINGLE_SHOT] = cr_q.single_shot;
                rdata_d[CR_IRQ_EN]      = cr_q.irq_en;
            end
            sel_sr: begin
                rdata_d[SR_ACTIVE]  = tmr_active;
                rdata_d[SR_MATCH]   = sr_q.match;
                rdata_d[SR_OVERRUN] = sr_q.overrun;
            end
            sel_cmpr: rdata_d = cmpr_q;
            sel_cntr: rdata_d = tmr_counter;
            sel_mcnt: rdata_d = 32'(mcnt_q);
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q     <= '0;
            sr_q     <= '0;
            cmpr_q   <= '0;
            mcnt_q   <= '0;
            trig_q   <= 1'b0;
            halt_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cr_q     <= cr_d;
            sr_q     <= sr_d;
            cmpr_q   <= cmpr_d;
            mcnt_q   <= mcnt_d;
            trig_q   <= trig_d;
            halt_q   <= halt_d;
            rvalid_q <= bus.req;
            rdata_q  <= rd ? rdata_d : '0;
        end
    end

    assign bus.gnt    = bus.req;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

    assign irq             = cr_q.irq_en & sr_q.match;
    assign tmr_trigger     = trig_q;
    assign tmr_halt        = halt_q;
    assign tmr_single_shot = cr_q.single_shot;
    assign tmr_compare     = cmpr_q;

endmodule

// File: tb/tb_timer_csr.sv
// Directed bench for timer_csr with a small behavioural timer core model.
// A second instance with a 2-bit match counter covers saturation.
module tb_timer_csr;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_csr_if #(.ADDR_WIDTH(5)) bus1 ();
    timer_csr_if #(.ADDR_WIDTH(5)) bus2 ();

    logic        irq, trig, halt, ss;
    logic [31:0] cmp;
    logic        core_active;
    logic        core_match;
    logic [31:0] core_cnt;
    logic        force_match = 1'b0;
    logic        tmatch;

    logic        irq2, trig2, halt2, ss2;
    logic [31:0] cmp2;
    logic        m2_match = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int trig_cnt = 0;

    assign tmatch = core_match | force_match;

    timer_csr #(.ADDR_WIDTH(5), .MATCH_CNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus1),
        .irq             (irq),
        .tmr_trigger     (trig),
        .tmr_halt        (halt),
        .tmr_single_shot (ss),
        .tmr_compare     (cmp),
        .tmr_active      (core_active),
        .tmr_match       (tmatch),
        .tmr_counter     (core_cnt)
    );

    timer_csr #(.ADDR_WIDTH(5), .MATCH_CNT_WIDTH(2)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus2),
        .irq             (irq2),
        .tmr_trigger     (trig2),
        .tmr_halt        (halt2),
        .tmr_single_shot (ss2),
        .tmr_compare     (cmp2),
        .tmr_active      (1'b0),
        .tmr_match       (m2_match),
        .tmr_counter     (32'd0)
    );

    // Timer core model: counts 0..compare, pulses match, stops if single shot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_active <= 1'b0;
            core_cnt    <= '0;
            core_match  <= 1'b0;
        end else begin
            core_match <= 1'b0;
            if (halt) begin
                core_active <= 1'b0;
            end else if (trig) begin
                core_active <= 1'b1;
                core_cnt    <= '0;
            end else if (core_active) begin
                if (core_cnt == cmp) begin
                    core_match <= 1'b1;
                    core_cnt   <= '0;
                    if (ss) core_active <= 1'b0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (trig) trig_cnt <= trig_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d,
                      input logic m);
        @(negedge clk);
        bus1.req   = 1'b1;
        bus1.we    = 1'b1;
        bus1.addr  = {idx, 2'b00};
        bus1.wdata = d;
        force_match = m;
        @(negedge clk);
        bus1.req    = 1'b0;
        bus1.we     = 1'b0;
        force_match = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] d);
        @(negedge clk);
        bus1.req  = 1'b1;
        bus1.we   = 1'b0;
        bus1.addr = {idx, 2'b00};
        @(negedge clk);
        bus1.req = 1'b0;
        d = bus1.rdata;
        check("rvalid", {31'd0, bus1.rvalid}, 32'd1);
    endtask

    logic [31:0] v;
    int          t0;

    initial begin
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'd0, bus1.rvalid}, 32'd0);
        check("rst_rdata", bus1.rdata, 32'd0);
        check("rst_outs", {28'd0, irq, trig, halt, ss}, 32'd0);
        check("rst_cmp", cmp, 32'd0);
        rst_n = 1'b1;

        // All mapped registers read zero after reset, unmapped too.
        for (int i = 0; i < 5; i++) begin
            rd(3'(i), v);
            check($sformatf("rst_reg%0d", i), v, 32'd0);
        end
        rd(3'd6, v);
        check("unmapped6", v, 32'd0);

        // Single shot run to compare 3.
        wr(IDX_CMPR, 32'd3, 1'b0);
        check("cmp3", cmp, 32'd3);
        wr(IDX_CR, 32'h5, 1'b0);
        check("trig_pulse", {30'd0, trig, ss}, 32'h3);
        @(negedge clk);
        check("trig_end", {31'd0, trig}, 32'd0);
        repeat (12) @(negedge clk);
        check("trig_count", trig_cnt, 32'd1);
        rd(IDX_SR, v);
        check("ss_sr", v, 32'h2);
        rd(IDX_MCNT, v);
        check("ss_mcnt", v, 32'd1);
        rd(IDX_CMPR, v);
        check("cmpr_rd", v, 32'd3);
        check("ss_irq", {31'd0, irq}, 32'd0);
        wr(IDX_SR, 32'h6, 1'b0);
        wr(IDX_MCNT, 32'h0, 1'b0);

        // Continuous run with irq enabled.
        wr(IDX_CR, 32'h8, 1'b0);
        check("cont_ss", {31'd0, ss}, 32'd0);
        wr(IDX_CMPR, 32'd1, 1'b0);
        wr(IDX_CR, 32'h9, 1'b0);
        repeat (10) @(negedge clk);
        check("cont_irq", {31'd0, irq}, 32'd1);
        rd(IDX_SR, v);
        check("cont_sr", v, 32'h7);

        // Halt with trigger also set: only halt pulses; irq_en drops.
        t0 = trig_cnt;
        wr(IDX_CR, 32'h3, 1'b0);
        check("halt_pulse", {30'd0, halt, trig}, 32'h2);
        check("irq_en_off", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("halt_end", {31'd0, halt}, 32'd0);
        repeat (5) @(negedge clk);
        check("no_trig", trig_cnt, t0);
        rd(IDX_SR, v);
        check("halted_sr", v, 32'h6);
        rd(IDX_CNTR, v);
        check("cntr", v, core_cnt);
        wr(IDX_CR, 32'h8, 1'b0);
        check("irq_back", {31'd0, irq}, 32'd1);
        wr(IDX_SR, 32'h6, 1'b0);
        check("irq_clr", {31'd0, irq}, 32'd0);
        rd(IDX_SR, v);
        check("sr_clr", v, 32'h0);

        // Same-cycle W1C and match.
        wr(IDX_SR, 32'h2, 1'b1);
        rd(IDX_SR, v);
        check("w1c_set0", v, 32'h2);
        wr(IDX_SR, 32'h2, 1'b1);
        rd(IDX_SR, v);
        check("w1c_set1", v, 32'h6);
        wr(IDX_MCNT, 32'h0, 1'b1);
        rd(IDX_MCNT, v);
        check("mcnt_clr_match", v, 32'd1);

        // Narrow counter saturates.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m2_match = 1'b1;
            @(negedge clk);
            m2_match = 1'b0;
        end
        @(negedge clk);
        bus2.req  = 1'b1;
        bus2.addr = {IDX_MCNT, 2'b00};
        @(negedge clk);
        bus2.req = 1'b0;
        check("sat_rvalid", {31'd0, bus2.rvalid}, 32'd1);
        check("sat_mcnt", bus2.rdata, 32'd3);

        // Reset during an outstanding read.
        wr(IDX_CR, 32'hC, 1'b0);
        @(negedge clk);
        bus1.req  = 1'b1;
        bus1.we   = 1'b0;
        bus1.addr = {IDX_CMPR, 2'b00};
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rvalid", {31'd0, bus1.rvalid}, 32'd0);
        check("mid_rdata", bus1.rdata, 32'd0);
        check("mid_outs", {28'd0, irq, trig, halt, ss}, 32'd0);
        check("mid_cmp", cmp, 32'd0);
        @(negedge clk);
        bus1.req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rvalid", {31'd0, bus1.rvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
